// File: rtl/x2050mvseq.sv
`default_nettype none
//============================================================================
// Module   : x2050mvseq
// Purpose  : Mover sequencer for 2050 storage-to-storage logical operations
//            (MVC, NC, OC, XC). A single command first programs the mover's
//            CPU-mode WFN register with an SS=38 cycle. It then streams one
//            byte per iteration from the U (second operand) and V (first
//            operand) sources through the mover. Each W result is returned
//            on a ready/valid port.
// Ports    : i_clk, i_reset        clock, synchronous active-high reset
//            i_start/i_op/i_len    command (accepted in IDLE only)
//            o_busy                high whenever not IDLE
//            i_u_* / o_u_ready     second-operand byte stream
//            i_v_* / o_v_ready     first-operand byte stream (unused by MVC)
//            o_u,o_v,o_e,o_ss,
//            o_ul,o_ur,
//            o_ros_advance,
//            o_io_mode             mover controls (CPU mode only)
//            i_w_reg               mover W output
//            o_w_* / i_w_ready     result byte stream
//            o_done, o_cc          end-of-operation pulse, condition code
// Config   : X2050_MVSEQ_CC_EN     when defined, track all-zero results and
//                                  report them on o_cc; otherwise o_cc = 0
// Revision : 1.0  initial release
//============================================================================
module x2050mvseq (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_start,
    input  logic [1:0] i_op,
    input  logic [7:0] i_len,
    output logic       o_busy,
    input  logic       i_u_valid,
    input  logic [7:0] i_u_data,
    output logic       o_u_ready,
    input  logic       i_v_valid,
    input  logic [7:0] i_v_data,
    output logic       o_v_ready,
    output logic [7:0] o_u,
    output logic [7:0] o_v,
    output logic [3:0] o_e,
    output logic [5:0] o_ss,
    output logic [1:0] o_ul,
    output logic [1:0] o_ur,
    output logic       o_ros_advance,
    output logic       o_io_mode,
    input  logic [7:0] i_w_reg,
    output logic       o_w_valid,
    output logic [7:0] o_w_data,
    input  logic       i_w_ready,
    output logic       o_done,
    output logic [1:0] o_cc
);

    localparam logic [1:0] c_OP_MVC = 2'd0;
    localparam logic [1:0] c_OP_NC  = 2'd1;
    localparam logic [1:0] c_OP_OC  = 2'd2;
    localparam logic [1:0] c_OP_XC  = 2'd3;
    localparam logic [5:0] c_SS_SETWFN = 6'd38;
    localparam logic [1:0] c_SEL_BYTE  = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETWFN = 3'd1,
        S_FETCH  = 3'd2,
        S_MOVE   = 3'd3,
        S_OUT    = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [1:0] r_op;
    logic [7:0] r_cnt;
    logic [7:0] r_u;
    logic [7:0] r_v;
    logic [7:0] r_w_data;
    logic       w_is_mvc;
    logic       w_xfer;

    assign w_is_mvc = (r_op == c_OP_MVC);

    // Both operand bytes are consumed together; MVC needs only the U byte.
    assign w_xfer = (r_state == S_FETCH) && i_u_valid && (w_is_mvc || i_v_valid);

    //------------------------------------------------------------------
    // State register
    //------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    //------------------------------------------------------------------
    // Next state and mover / handshake controls
    //------------------------------------------------------------------
    always_comb begin
        w_next        = r_state;
        o_ss          = 6'd0;
        o_e           = 4'd0;
        o_ros_advance = 1'b0;
        o_ul          = 2'd0;
        o_ur          = 2'd0;
        o_u           = r_u;
        // MVC never presents a first-operand byte to the mover.
        o_v           = w_is_mvc ? 8'h00 : r_v;
        o_u_ready     = 1'b0;
        o_v_ready     = 1'b0;
        o_w_valid     = 1'b0;
        o_done        = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_next = S_SETWFN;
                end
            end
            S_SETWFN: begin
                o_ss          = c_SS_SETWFN;
                o_ros_advance = 1'b1;
                case (r_op)
                    c_OP_MVC: o_e = 4'b0100;
                    c_OP_NC:  o_e = 4'b0010;
                    c_OP_OC:  o_e = 4'b0001;
                    c_OP_XC:  o_e = 4'b0011;
                    default:  o_e = 4'b0000;
                endcase
                w_next = S_FETCH;
            end
            S_FETCH: begin
                o_u_ready = 1'b1;
                o_v_ready = !w_is_mvc;
                if (w_xfer) begin
                    w_next = S_MOVE;
                end
            end
            S_MOVE: begin
                o_ul   = c_SEL_BYTE;
                o_ur   = c_SEL_BYTE;
                w_next = S_OUT;
            end
            S_OUT: begin
                o_w_valid = 1'b1;
                if (i_w_ready) begin
                    // Count reaches 0 on the last byte, so L=255 yields
                    // 256 bytes without the counter wrapping.
                    w_next = (r_cnt == 8'd0) ? S_DONE : S_FETCH;
                end
            end
            S_DONE: begin
                o_done = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    //------------------------------------------------------------------
    // Command, operand and result registers
    //------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_op     <= 2'd0;
            r_cnt    <= 8'd0;
            r_u      <= 8'd0;
            r_v      <= 8'd0;
            r_w_data <= 8'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_op  <= i_op;
                        r_cnt <= i_len;
                    end
                end
                S_FETCH: begin
                    if (w_xfer) begin
                        r_u <= i_u_data;
                        r_v <= i_v_data;
                    end
                end
                S_MOVE: begin
                    r_w_data <= i_w_reg;
                end
                S_OUT: begin
                    if (i_w_ready && (r_cnt != 8'd0)) begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_busy    = (r_state != S_IDLE);
    assign o_w_data  = r_w_data;
    assign o_io_mode = 1'b0;

`ifdef X2050_MVSEQ_CC_EN
    // Set once any result byte is nonzero; cleared when a command is taken.
    logic r_nz;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_nz <= 1'b0;
        end else if ((r_state == S_IDLE) && i_start) begin
            r_nz <= 1'b0;
        end else if ((r_state == S_MOVE) && (i_w_reg != 8'h00)) begin
            r_nz <= 1'b1;
        end
    end

    // MVC always reports CC 0.
    assign o_cc = (r_nz && !w_is_mvc) ? 2'b01 : 2'b00;
`else
    assign o_cc = 2'b00;
`endif

endmodule

`default_nettype wire

// File: tb/tb_x2050mvseq.sv
`default_nettype none
//============================================================================
// Module   : tb_x2050mvseq
// Purpose  : Self-checking bench for x2050mvseq. It models the external
//            mover (WFN register and W datapath) and drives the operand
//            sources and the result sink. It compares results, condition
//            code and timing against expectations computed by the bench.
// Revision : 1.0  initial release
//============================================================================
module tb_x2050mvseq;

`ifdef X2050_MVSEQ_CC_EN
    localparam bit CC_EN = 1'b1;
`else
    localparam bit CC_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       i_reset = 1'b1;
    logic       i_start = 1'b0;
    logic [1:0] i_op = 2'd0;
    logic [7:0] i_len = 8'd0;
    logic       o_busy;
    logic       i_u_valid = 1'b0;
    logic [7:0] i_u_data = 8'd0;
    logic       o_u_ready;
    logic       i_v_valid = 1'b0;
    logic [7:0] i_v_data = 8'd0;
    logic       o_v_ready;
    logic [7:0] o_u, o_v;
    logic [3:0] o_e;
    logic [5:0] o_ss;
    logic [1:0] o_ul, o_ur;
    logic       o_ros_advance, o_io_mode;
    logic [7:0] i_w_reg;
    logic       o_w_valid;
    logic [7:0] o_w_data;
    logic       i_w_ready = 1'b0;
    logic       o_done;
    logic [1:0] o_cc;

    always #5 clk = ~clk;

    x2050mvseq dut (
        .i_clk(clk), .i_reset(i_reset), .i_start(i_start), .i_op(i_op),
        .i_len(i_len), .o_busy(o_busy),
        .i_u_valid(i_u_valid), .i_u_data(i_u_data), .o_u_ready(o_u_ready),
        .i_v_valid(i_v_valid), .i_v_data(i_v_data), .o_v_ready(o_v_ready),
        .o_u(o_u), .o_v(o_v), .o_e(o_e), .o_ss(o_ss), .o_ul(o_ul), .o_ur(o_ur),
        .o_ros_advance(o_ros_advance), .o_io_mode(o_io_mode),
        .i_w_reg(i_w_reg), .o_w_valid(o_w_valid), .o_w_data(o_w_data),
        .i_w_ready(i_w_ready), .o_done(o_done), .o_cc(o_cc)
    );

    // External mover: WFN register loaded by an SS=38 ROS-advance cycle;
    // W shows the WFN function of U/V only when both byte selects are 3.
    logic [3:0] wfn = 4'd0;
    always @(posedge clk) if (o_ros_advance && o_ss == 6'd38) wfn <= o_e;
    always_comb begin
        i_w_reg = 8'hEE;
        if (o_ul == 2'd3 && o_ur == 2'd3) begin
            case (wfn)
                4'b0100: i_w_reg = o_u;
                4'b0010: i_w_reg = o_u & o_v;
                4'b0001: i_w_reg = o_u | o_v;
                4'b0011: i_w_reg = o_u ^ o_v;
                default: i_w_reg = 8'hEE;
            endcase
        end
    end

    wire [46:0] all_outs = {o_busy, o_done, o_u_ready, o_v_ready, o_w_valid,
                            o_ros_advance, o_w_data, o_u, o_v, o_e, o_ss,
                            o_ul, o_ur, o_cc, o_io_mode};

    int total = 0;
    int bad   = 0;

    logic [7:0] ub [0:255];
    logic [7:0] vb [0:255];
    logic [7:0] eb [0:255];
    logic [1:0] ecc;
    logic [3:0] exp_e [0:3];

    typedef struct packed {
        logic [1:0]  op;
        logic [7:0]  len;
        logic [23:0] u;
        logic [23:0] v;
        logic [23:0] r;
        logic        cc;
    } vec_t;

    vec_t tbl [0:5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] ref_byte(input logic [1:0] op, input logic [7:0] u, input logic [7:0] v);
        case (op)
            2'd0:    return u;
            2'd1:    return u & v;
            2'd2:    return u | v;
            default: return u ^ v;
        endcase
    endfunction

    // Runs one operation using ub/vb as operand bytes and eb/ecc as expected
    // results. vstall/wstall: cycles of V-invalid / W-not-ready on byte 1.
    task automatic run_op(input logic [1:0] op, input int len, input int vstall,
                          input int wstall, input bit rnd, input bit repulse,
                          input bit rst_at, input bit timed);
        int ui, wi, cyc, ss_cnt, sv, sw, done_cyc;
        bit vr_seen, unstable, pend, done_seen, uv, vv, wr, rst_bad;
        logic [7:0] pd;
        logic [3:0] e_at_ss;
        ui = 0; wi = 0; ss_cnt = 0; sv = vstall; sw = wstall; done_cyc = -1;
        vr_seen = 0; unstable = 0; pend = 0; done_seen = 0; pd = 0; e_at_ss = 0;

        @(negedge clk);
        i_op = op; i_len = len[7:0]; i_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_start = 1'b0;
        cyc = 1;
        while (!done_seen && cyc < 6000) begin
            // A re-pulse with a different command must be ignored.
            i_start = repulse && (cyc == 5);
            if (i_start) begin i_op = 2'd0; i_len = 8'd0; end
            uv = (ui <= len);
            vv = (op != 2'd0) && (ui <= len);
            if (rnd) begin
                if ($urandom_range(0, 3) == 0) uv = 0;
                if ($urandom_range(0, 3) == 0) vv = 0;
            end
            if (o_u_ready && ui == 1 && sv > 0) begin vv = 0; sv--; end
            i_u_valid = uv;
            i_u_data  = (ui <= len && ui < 256) ? ub[ui] : 8'h00;
            i_v_valid = vv;
            i_v_data  = (op == 2'd0) ? 8'($urandom) : ((ui <= len && ui < 256) ? vb[ui] : 8'h00);
            if (o_u_ready && uv && (op == 2'd0 || (o_v_ready && vv))) ui++;

            if (op == 2'd0 && (o_v_ready || o_v != 8'h00)) vr_seen = 1;
            if (o_ss == 6'd38 && o_ros_advance) begin ss_cnt++; e_at_ss = o_e; end

            wr = 1;
            if (rnd && $urandom_range(0, 2) == 0) wr = 0;
            if (o_w_valid && wi == 1 && sw > 0) begin wr = 0; sw--; end
            if (pend && (!o_w_valid || o_w_data !== pd)) unstable = 1;

            if (rst_at && o_w_valid && wi == 1) begin
                i_w_ready = 1'b0;
                i_reset = 1'b1;
                @(posedge clk);
                @(negedge clk);
                chk("reset_mid_op_outputs", 64'(all_outs), 64'd0);
                i_reset = 1'b0;
                i_u_valid = 1'b0; i_v_valid = 1'b0;
                rst_bad = 0;
                for (int k = 0; k < 4; k++) begin
                    @(posedge clk);
                    @(negedge clk);
                    if (o_busy || o_done || o_w_valid) rst_bad = 1;
                end
                chk("reset_no_resume", 64'(rst_bad), 64'd0);
                return;
            end

            i_w_ready = wr;
            pend = 0;
            if (o_w_valid) begin
                if (wr) begin
                    if (wi <= len) chk("result_byte", 64'(o_w_data), 64'(eb[wi]));
                    else chk("extra_result", 64'(wi), 64'(len));
                    wi++;
                end else begin
                    pend = 1;
                    pd = o_w_data;
                end
            end
            if (o_done) begin
                done_seen = 1;
                done_cyc = cyc;
                chk("busy_cc_at_done", 64'({o_busy, o_cc}), 64'({1'b1, ecc}));
            end
            if (!done_seen) begin
                @(posedge clk);
                @(negedge clk);
                cyc++;
            end
        end
        i_u_valid = 1'b0; i_v_valid = 1'b0; i_w_ready = 1'b0; i_start = 1'b0;

        chk("done_seen", 64'(done_seen), 64'd1);
        chk("result_count", 64'(wi), 64'(len + 1));
        chk("setwfn_cycles", 64'(ss_cnt), 64'd1);
        chk("setwfn_e", 64'(e_at_ss), 64'(exp_e[op]));
        chk("wfn_loaded", 64'(wfn), 64'(exp_e[op]));
        chk("w_data_stable", 64'(unstable), 64'd0);
        if (op == 2'd0) chk("mvc_v_idle", 64'(vr_seen), 64'd0);
        if (timed) chk("done_cycle", 64'(done_cyc), 64'(3 * (len + 1) + 2));
        @(posedge clk);
        @(negedge clk);
        chk("idle_after_done", 64'({o_done, o_busy}), 64'd0);
        chk("cc_hold", 64'(o_cc), 64'(ecc));
    endtask

    task automatic load_vec(input vec_t t);
        for (int i = 0; i < 3; i++) begin
            ub[i] = t.u[8*i +: 8];
            vb[i] = t.v[8*i +: 8];
            eb[i] = t.r[8*i +: 8];
        end
        ecc = {1'b0, t.cc & CC_EN};
    endtask

    initial begin
        logic [1:0] rop;
        int rlen;
        bit nz;
        exp_e[0] = 4'b0100; exp_e[1] = 4'b0010; exp_e[2] = 4'b0001; exp_e[3] = 4'b0011;
        //              op     len    u            v            result       cc
        tbl[0] = '{2'd0, 8'd2, 24'hC3C2C1, 24'h000000, 24'hC3C2C1, 1'b0};
        tbl[1] = '{2'd3, 8'd0, 24'h00005A, 24'h00005A, 24'h000000, 1'b0};
        tbl[2] = '{2'd1, 8'd1, 24'h000FF0, 24'h003C3C, 24'h000C30, 1'b1};
        tbl[3] = '{2'd2, 8'd0, 24'h000080, 24'h000001, 24'h000081, 1'b1};
        tbl[4] = '{2'd3, 8'd1, 24'h0000FF, 24'h00000F, 24'h0000F0, 1'b1};
        tbl[5] = '{2'd1, 8'd0, 24'h0000AA, 24'h000055, 24'h000000, 1'b0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        i_reset = 1'b0;
        @(negedge clk);
        chk("reset_state", 64'(all_outs), 64'd0);

        // Directed table, no stalls, with exact timing.
        for (int t = 0; t < 6; t++) begin
            load_vec(tbl[t]);
            run_op(tbl[t].op, int'(tbl[t].len), 0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        end

        // NC with a 5-cycle V stall and a 4-cycle W stall on byte 1.
        load_vec(tbl[2]);
        run_op(tbl[2].op, int'(tbl[2].len), 5, 4, 1'b0, 1'b0, 1'b0, 1'b0);

        // XC L=255 of zeros with a start re-pulse while busy.
        for (int i = 0; i < 256; i++) begin ub[i] = 8'h00; vb[i] = 8'h00; eb[i] = 8'h00; end
        ecc = 2'b00;
        run_op(2'd3, 255, 0, 0, 1'b0, 1'b1, 1'b0, 1'b1);

        // Reset in OUT of byte 2 of a 4-byte MVC, then a clean MVC.
        for (int i = 0; i < 4; i++) begin ub[i] = 8'(8'h11 * (i + 1)); eb[i] = ub[i]; end
        ecc = 2'b00;
        run_op(2'd0, 3, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
        load_vec(tbl[0]);
        run_op(2'd0, 2, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Random operations with random stalls against the reference model.
        for (int n = 0; n < 16; n++) begin
            rop  = 2'($urandom_range(0, 3));
            rlen = $urandom_range(0, 9);
            nz   = 0;
            for (int i = 0; i <= rlen; i++) begin
                ub[i] = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
                vb[i] = ($urandom_range(0, 3) == 0) ? ub[i] : 8'($urandom);
                eb[i] = ref_byte(rop, ub[i], vb[i]);
                if (eb[i] != 8'h00) nz = 1;
            end
            ecc = {1'b0, CC_EN && nz && (rop != 2'd0)};
            run_op(rop, rlen, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
